// File: rtl/apb_initiator_if.sv
// Bundle for the command/response handshake and the APB bus of apb_initiator.
// The initiator uses modport master; the command source/responder side uses slave.
interface apb_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_write;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic [15:0] paddr;
    logic [7:0]  pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [7:0]  prdata;
    logic        pready;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, rsp_ready, prdata, pready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output paddr, pwdata, pwrite, psel, penable
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, rsp_ready, prdata, pready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/apb_initiator.sv
// Single-outstanding APB requester: one valid/ready command becomes one SETUP/ACCESS
// transfer, with a bounded wait on pready that turns a hung responder into an error.
module apb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clk,
    input logic             n_rst,
    apb_initiator_if.master bus
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          timeout_hit;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_rdata_q;
    logic          rsp_error_q;
    logic [15:0]   paddr_q;
    logic [7:0]    pwdata_q;
    logic          pwrite_q;
    logic          psel_q;
    logic          penable_q;

    // Wait counter saturates instead of wrapping, which matters when the timeout is disabled.
    always_comb begin
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        paddr_q     <= bus.req_addr;
                        pwdata_q    <= bus.req_wdata;
                        pwrite_q    <= bus.req_write;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        req_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A pready arriving on the final allowed cycle still counts as success.
                    if (bus.pready) begin
                        rsp_rdata_q <= pwrite_q ? 8'h00 : bus.prdata;
                        rsp_error_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= 8'h00;
                        rsp_error_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;

endmodule
